// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the loadable down-counter.
package down_counter_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/down_counter_load.sv
// Loadable down-counter with one-shot / auto-reload modes and a registered
// one-cycle Tick at terminal count. Used as a rate divider / interval timer.
module down_counter_load
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Enable,
  input  logic             LoadValid,
  output logic             LoadReady,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             AutoReload,
  input  logic             Stop,
  output logic [WIDTH-1:0] CounterValue,
  output logic             Tick,
  output logic             Busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tick_d;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      Tick     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      Tick     <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tick_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (LoadValid) begin
          count_d  = LoadValue;
          reload_d = LoadValue;
          // A zero load terminates immediately and never enters RUN.
          if (LoadValue == '0) tick_d  = 1'b1;
          else                 state_d = RUN;
        end
      end
      RUN: begin
        if (Stop) begin
          state_d = IDLE;
        end else if (Enable) begin
          if (count_q == WIDTH'(1)) begin
            tick_d = 1'b1;
            if (AutoReload) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign CounterValue = count_q;
  assign LoadReady    = (state_q == IDLE);
  assign Busy         = (state_q == RUN);

endmodule

// File: doc/down_counter_load.md
Name: down_counter_load

Overview:
- Loadable WIDTH-bit down-counter with a load handshake, one-shot or auto-reload mode, and a one-cycle terminal-count pulse (Tick).
- Complements the existing T-flip-flop up-counter. It consumes a count value and counts it down, instead of producing an incrementing count.
- Used as a rate divider and interval timer, e.g. producing a 0.5 s enable for display and Morse-style sequencers in later labs.

Parameters:
- WIDTH, 8, bit width of the counter, LoadValue and CounterValue.

Ports:
- Clock  input  1  single system clock; all state changes on posedge.
- Resetn  input  1  asynchronous, active-low reset.
- Enable  input  1  count-enable; decrement occurs only in RUN with Enable=1.
- LoadValid  input  1  LoadValue is valid this cycle.
- LoadReady  output  1  block accepts a load this cycle; equals (state==IDLE).
- LoadValue  input  WIDTH  start/reload count.
- AutoReload  input  1  1 = periodic mode, 0 = one-shot; sampled at each terminal event.
- Stop  input  1  synchronous abort of a running count.
- CounterValue  output  WIDTH  current count (registered).
- Tick  output  1  registered one-cycle pulse at terminal count.
- Busy  output  1  equals (state==RUN).

Behaviour:
- Reset: Resetn=0 asynchronously forces state=IDLE, CounterValue=0, ReloadReg=0, Tick=0. This gives LoadReady=1 and Busy=0.
- Reset asserted mid-count takes effect immediately. No Tick is issued.
- States (state_t): IDLE and RUN.

IDLE:
- LoadReady=1.
- A load is accepted when LoadValid=1 on a posedge. It sets CounterValue<=LoadValue and ReloadReg<=LoadValue.
  - LoadValue!=0: next state is RUN.
  - LoadValue==0: Tick=1 on the next cycle; state stays IDLE, regardless of AutoReload.
- Enable and Stop are ignored in IDLE. CounterValue holds.

RUN:
- LoadReady=0. LoadValid is ignored; there is no queuing.
- Priority order per cycle: Stop, then Enable.
- Stop=1: next state is IDLE. CounterValue holds its current value. No Tick.
- Enable=0: all state holds.
- Enable=1 and CounterValue>1: CounterValue<=CounterValue-1.
- Enable=1 and CounterValue==1 (terminal event): Tick<=1 on the same edge.
  - AutoReload=1: CounterValue<=ReloadReg; stay in RUN.
  - AutoReload=0: CounterValue<=0; next state is IDLE.

Timing and arithmetic rules:
- Tick is high for exactly one cycle per terminal event and is low in every other cycle.
- Load-to-first-Tick latency is N enabled cycles after the load edge, where N=LoadValue.
- Auto-reload period is N enabled cycles.
- Decrement is modulo 2^WIDTH, but underflow is unreachable: RUN is never entered with 0.
- The maximum load, 2^WIDTH-1, is legal and gives a period of 255 enabled cycles at WIDTH=8.
- A load on the cycle after a one-shot Tick is accepted, because the block is back in IDLE.

Decomposition:
- Package down_counter_pkg holds:
  - typedef enum logic {IDLE, RUN} state_t;
  - localparam default WIDTH=8.
- No sub-module is needed. The block is one always_ff (async reset) for state, CounterValue, ReloadReg and Tick, plus continuous assigns for LoadReady and Busy.

Test Plan:
1. Reset then one-shot.
   - Stimulus: Resetn=0 for 2 cycles, then 1. Load 5 with AutoReload=0, Enable=1 held.
   - Required: CounterValue 5,4,3,2,1,0. Tick=1 exactly in the cycle CounterValue becomes 0. Busy falls the same cycle; LoadReady=1 after.
2. Auto-reload.
   - Stimulus: load 3, AutoReload=1, Enable=1 for 10 cycles.
   - Required: CounterValue 3,2,1,3,2,1,3,... Tick pulses every 3rd cycle, 3 pulses total. Busy stays 1.
3. Enable gating.
   - Stimulus: load 4, Enable toggled 1,0,0,1,1,1.
   - Required: CounterValue 4,3,3,3,2,1,0. Tick only on the final transition.
4. Stop and ignored load.
   - Stimulus: load 10, 3 enabled cycles (value 7). Assert LoadValid with LoadValue=99 while in RUN, then Stop=1 with Enable=1.
   - Required: load 99 ignored. After Stop: IDLE, CounterValue=7, no Tick.
5. Zero and maximum loads.
   - Stimulus: load 0, then load 255 with AutoReload=0.
   - Required: load 0 gives a single Tick and the block stays IDLE. Load 255 gives a Tick after exactly 255 enabled cycles.
6. Async reset mid-count.
   - Stimulus: load 8; drop Resetn between clock edges at CounterValue=5.
   - Required: CounterValue=0, Tick=0, LoadReady=1 immediately, without waiting for a clock edge.
